crc32_rx_checker: RTL and testbench

CRC32_RX_CHECKER -- requirements
Module: crc32_rx_checker

---
 rtl/crc32_pkg.sv | 30 +++
 rtl/crc32_word_update.sv | 13 +
 rtl/crc32_rx_checker.sv | 176 +++++++++++++++++
 tb/tb_crc32_rx_checker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the receive checker and the transmit generator:
// polynomial, initial value, checker FSM state encoding and the word-wide update.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } crc_state_t;

  // Fold one 32-bit word into the reflected CRC register, LSB first.
  // XORing the whole word in up front is equivalent to the bit-serial form.
  function automatic logic [31:0] crc32_update_word(input logic [31:0] crc,
                                                    input logic [31:0] data);
    logic [31:0] c;
    c = crc ^ data;
    for (int i = 0; i < 32; i++) begin
      if (c[0]) begin
        c = {1'b0, c[31:1]} ^ CRC32_POLY_REFL;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_word_update.sv
// Combinational 32-bit parallel next-CRC stage (reflected CRC-32).
// Shared between the receive checker and the transmit generator.
module crc32_word_update
  import crc32_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);

  assign crc_out = crc32_update_word(crc_in, data_in);

endmodule

// File: rtl/crc32_rx_checker.sv
// Receive-side CRC-32 checker: accumulates the CRC over payload words, compares
// it against the trailing FCS word and emits a registered one-cycle verdict.
// Optional verdict statistics are enabled by defining CRC32_CHK_STATS_EN;
// without it good_cnt/bad_cnt are constant zero.
module crc32_rx_checker
  import crc32_pkg::*;
#(
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start_of_packet,
  input  logic        last_word,
  input  logic [31:0] data_in,
  output logic        valid_out,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        proto_err,
  output logic [31:0] crc_calc,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam int WCNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [WCNT_W-1:0] MAX_CNT = WCNT_W'(MAX_WORDS);

  crc_state_t        state_r, state_nx_s;
  logic [31:0]       crc_r, crc_nx_s, upd_base_s, upd_s;
  logic [WCNT_W-1:0] wcnt_r, wcnt_nx_s;
  logic              vld_nx_s, ok_nx_s, err_nx_s, perr_nx_s;
  logic [31:0]       calc_nx_s;

  // A start-of-packet word always seeds the CRC from the initial value.
  always_comb begin
    upd_base_s = crc_r;
    if (start_of_packet) begin
      upd_base_s = CRC32_INIT;
    end else begin
      upd_base_s = crc_r;
    end
  end

  crc32_word_update u_upd (
    .crc_in  (upd_base_s),
    .data_in (data_in),
    .crc_out (upd_s)
  );

  // Next-state, CRC accumulation and verdict decode; nothing moves without enable.
  always_comb begin
    state_nx_s = state_r;
    crc_nx_s   = crc_r;
    wcnt_nx_s  = wcnt_r;
    vld_nx_s   = 1'b0;
    ok_nx_s    = 1'b0;
    err_nx_s   = 1'b0;
    perr_nx_s  = 1'b0;
    calc_nx_s  = 32'h0000_0000;
    if (enable) begin
      if (start_of_packet && last_word) begin
        // Runt: a packet with no payload is always an error.
        vld_nx_s   = 1'b1;
        err_nx_s   = 1'b1;
        perr_nx_s  = 1'b1;
        calc_nx_s  = ~crc_r;
        state_nx_s = ST_IDLE;
        crc_nx_s   = CRC32_INIT;
        wcnt_nx_s  = '0;
      end else if (start_of_packet) begin
        if (state_r == ST_ACTIVE) begin
          // Unterminated packet: abort it, then start the new one this cycle.
          vld_nx_s  = 1'b1;
          err_nx_s  = 1'b1;
          perr_nx_s = 1'b1;
          calc_nx_s = ~crc_r;
        end else begin
          vld_nx_s = 1'b0;
        end
        state_nx_s = ST_ACTIVE;
        crc_nx_s   = upd_s;
        wcnt_nx_s  = WCNT_W'(1);
      end else begin
        case (state_r)
          ST_ACTIVE: begin
            if (wcnt_r == MAX_CNT) begin
              // Packet is longer than the limit: abort and drop the remainder.
              vld_nx_s   = 1'b1;
              err_nx_s   = 1'b1;
              perr_nx_s  = 1'b1;
              calc_nx_s  = ~crc_r;
              state_nx_s = ST_DROP;
              crc_nx_s   = CRC32_INIT;
              wcnt_nx_s  = '0;
            end else if (last_word) begin
              // FCS word is compared only, never folded into the CRC.
              vld_nx_s   = 1'b1;
              ok_nx_s    = (~crc_r == data_in);
              err_nx_s   = (~crc_r != data_in);
              calc_nx_s  = ~crc_r;
              state_nx_s = ST_IDLE;
              crc_nx_s   = CRC32_INIT;
              wcnt_nx_s  = '0;
            end else begin
              crc_nx_s  = upd_s;
              wcnt_nx_s = wcnt_r + WCNT_W'(1);
            end
          end
          ST_IDLE: begin
            // Stray word outside a packet: discard and flag framing.
            perr_nx_s = 1'b1;
          end
          ST_DROP: begin
            state_nx_s = ST_DROP;
          end
          default: begin
            state_nx_s = ST_IDLE;
            crc_nx_s   = CRC32_INIT;
            wcnt_nx_s  = '0;
          end
        endcase
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // FSM state, CRC register, word count and registered verdict outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      crc_r     <= CRC32_INIT;
      wcnt_r    <= '0;
      valid_out <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      proto_err <= 1'b0;
      crc_calc  <= 32'h0000_0000;
    end else begin
      state_r   <= state_nx_s;
      crc_r     <= crc_nx_s;
      wcnt_r    <= wcnt_nx_s;
      valid_out <= vld_nx_s;
      crc_ok    <= ok_nx_s;
      crc_err   <= err_nx_s;
      proto_err <= perr_nx_s;
      crc_calc  <= calc_nx_s;
    end
  end

`ifdef CRC32_CHK_STATS_EN
  logic [15:0] good_cnt_r, bad_cnt_r;

  // Saturating verdict counters, updated together with the verdict strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      good_cnt_r <= 16'h0000;
      bad_cnt_r  <= 16'h0000;
    end else begin
      if (ok_nx_s && (good_cnt_r != 16'hFFFF)) begin
        good_cnt_r <= good_cnt_r + 16'd1;
      end
      if (err_nx_s && (bad_cnt_r != 16'hFFFF)) begin
        bad_cnt_r <= bad_cnt_r + 16'd1;
      end
    end
  end

  assign good_cnt = good_cnt_r;
  assign bad_cnt  = bad_cnt_r;
`else
  assign good_cnt = 16'h0000;
  assign bad_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_crc32_rx_checker.sv
// Scoreboard bench for crc32_rx_checker (MAX_WORDS=4): the driver pushes the
// expected response with its due cycle, a negedge monitor pops and compares.
module tb_crc32_rx_checker;

  localparam logic [31:0] POLY = 32'hEDB8_8320;
`ifdef CRC32_CHK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        start_of_packet = 1'b0;
  logic        last_word = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        valid_out, crc_ok, crc_err, proto_err;
  logic [31:0] crc_calc;
  logic [15:0] good_cnt, bad_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_good = 0;
  int exp_bad  = 0;

  typedef struct {
    int          due;
    bit          vld;
    bit          ok;
    bit          err;
    bit          perr;
    bit          chk_calc;
    logic [31:0] calc;
    logic [15:0] good;
    logic [15:0] bad;
  } exp_t;
  exp_t sb[$];

  crc32_rx_checker #(.MAX_WORDS(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .start_of_packet(start_of_packet), .last_word(last_word), .data_in(data_in),
    .valid_out(valid_out), .crc_ok(crc_ok), .crc_err(crc_err), .proto_err(proto_err),
    .crc_calc(crc_calc), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bit-serial reference CRC step, LSB first.
  function automatic logic [31:0] ref_step(input logic [31:0] crc, input logic [31:0] w);
    logic [31:0] c;
    logic fb;
    c = crc;
    for (int i = 0; i < 32; i++) begin
      fb = c[0] ^ w[i];
      c  = c >> 1;
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  task automatic send(input bit sop, input bit last, input logic [31:0] d);
    @(negedge clk);
    enable = 1'b1; start_of_packet = sop; last_word = last; data_in = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enable = 1'b0; start_of_packet = 1'b0; last_word = 1'b0; data_in = 32'h0;
    end
  endtask

  // Push the response expected one cycle after the word just driven.
  task automatic expect_resp(input bit vld, input bit ok, input bit err, input bit perr,
                             input bit chk_calc, input logic [31:0] calc);
    exp_t e;
    if (ok)  exp_good++;
    if (err) exp_bad++;
    e.due = cyc + 1; e.vld = vld; e.ok = ok; e.err = err; e.perr = perr;
    e.chk_calc = chk_calc; e.calc = calc;
    e.good = STATS ? 16'(exp_good) : 16'h0;
    e.bad  = STATS ? 16'(exp_bad)  : 16'h0;
    sb.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, {31'h0, valid_out}, 32'h0);
    check({tag, "_ok"},    {31'h0, crc_ok},    32'h0);
    check({tag, "_err"},   {31'h0, crc_err},   32'h0);
    check({tag, "_perr"},  {31'h0, proto_err}, 32'h0);
    check({tag, "_calc"},  crc_calc,           32'h0);
    check({tag, "_good"},  {16'h0, good_cnt},  32'h0);
    check({tag, "_bad"},   {16'h0, bad_cnt},   32'h0);
  endtask

  // Monitor: pop and compare whenever the DUT presents a verdict or proto_err.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      check("missing_response", 32'h0, 32'h1);
    end
    if (!valid_out) begin
      check("idle_outputs_zero", {30'h0, crc_ok, crc_err} | crc_calc, 32'h0);
    end
    if (valid_out || proto_err) begin
      if (sb.size() == 0 || sb[0].due != cyc) begin
        check("unexpected_response", {30'h0, valid_out, proto_err}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("valid_out", {31'h0, valid_out}, {31'h0, e.vld});
        check("crc_ok",    {31'h0, crc_ok},    {31'h0, e.ok});
        check("crc_err",   {31'h0, crc_err},   {31'h0, e.err});
        check("proto_err", {31'h0, proto_err}, {31'h0, e.perr});
        if (e.chk_calc) check("crc_calc", crc_calc, e.calc);
        check("good_cnt", {16'h0, good_cnt}, {16'h0, e.good});
        check("bad_cnt",  {16'h0, bad_cnt},  {16'h0, e.bad});
      end
    end
  end

  initial begin
    logic [31:0] fcs_a, fcs_z;
    fcs_a = ~ref_step(ref_step(32'hFFFF_FFFF, 32'hDEAD_BEEF), 32'hCAFE_BABE);
    fcs_z = ~ref_step(ref_step(ref_step(32'hFFFF_FFFF, 32'h0), 32'h0), 32'h0);

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    // Good single-word packet with enable gaps inside it.
    send(1'b1, 1'b0, 32'h1234_5678);
    idle(2);
    send(1'b0, 1'b1, 32'hAF6D_87D2); expect_resp(1, 1, 0, 0, 1, 32'hAF6D_87D2);
    idle(2);

    // Corrupted FCS.
    send(1'b1, 1'b0, 32'h1234_5678);
    send(1'b0, 1'b1, 32'hAF6D_87D3); expect_resp(1, 0, 1, 0, 1, 32'hAF6D_87D2);

    // Back-to-back packets with no gap.
    send(1'b1, 1'b0, 32'hDEAD_BEEF);
    send(1'b0, 1'b0, 32'hCAFE_BABE);
    send(1'b0, 1'b1, fcs_a);         expect_resp(1, 1, 0, 0, 1, fcs_a);
    send(1'b1, 1'b0, 32'h1234_5678);
    send(1'b0, 1'b1, 32'hAF6D_87D2); expect_resp(1, 1, 0, 0, 1, 32'hAF6D_87D2);

    // Three words then a new sop: abort, then the new packet passes.
    send(1'b1, 1'b0, 32'h0000_0001);
    send(1'b0, 1'b0, 32'h0000_0002);
    send(1'b0, 1'b0, 32'h0000_0003);
    send(1'b1, 1'b0, 32'h1234_5678); expect_resp(1, 0, 1, 1, 0, 32'h0);
    send(1'b0, 1'b1, 32'hAF6D_87D2); expect_resp(1, 1, 0, 0, 1, 32'hAF6D_87D2);

    // Stray words in IDLE and a runt in IDLE and in ACTIVE.
    send(1'b0, 1'b0, 32'h5555_AAAA); expect_resp(0, 0, 0, 1, 0, 32'h0);
    send(1'b0, 1'b1, 32'h5555_AAAA); expect_resp(0, 0, 0, 1, 0, 32'h0);
    send(1'b1, 1'b1, 32'h1111_2222); expect_resp(1, 0, 1, 1, 0, 32'h0);
    send(1'b1, 1'b0, 32'h3333_4444);
    send(1'b1, 1'b1, 32'h1111_2222); expect_resp(1, 0, 1, 1, 0, 32'h0);
    idle(1);

    // Overlong packet: abort on word 5, word 6 and strays in DROP are silent.
    send(1'b1, 1'b0, 32'h0000_0010);
    send(1'b0, 1'b0, 32'h0000_0020);
    send(1'b0, 1'b0, 32'h0000_0030);
    send(1'b0, 1'b0, 32'h0000_0040);
    send(1'b0, 1'b0, 32'h0000_0050); expect_resp(1, 0, 1, 1, 0, 32'h0);
    send(1'b0, 1'b1, 32'h0000_0060);
    send(1'b0, 1'b0, 32'h0000_0070);
    idle(2);
    // Maximum-length packet (3 zero words + FCS) from DROP passes.
    send(1'b1, 1'b0, 32'h0);
    send(1'b0, 1'b0, 32'h0);
    send(1'b0, 1'b0, 32'h0);
    send(1'b0, 1'b1, fcs_z);         expect_resp(1, 1, 0, 0, 1, fcs_z);
    idle(2);

    // Reset mid-packet: no verdict, no proto_err, counters cleared.
    send(1'b1, 1'b0, 32'h0BAD_F00D);
    send(1'b0, 1'b0, 32'h0BAD_F00D);
    @(negedge clk);
    enable = 1'b0; start_of_packet = 1'b0; last_word = 1'b0; reset = 1'b1;
    exp_good = 0; exp_bad = 0;
    repeat (2) @(negedge clk);
    check_reset_state("midreset");
    reset = 1'b0;
    send(1'b1, 1'b0, 32'h1234_5678);
    send(1'b0, 1'b1, 32'hAF6D_87D2); expect_resp(1, 1, 0, 0, 1, 32'hAF6D_87D2);
    idle(4);

    check("scoreboard_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
